// File: rtl/arm_pkg.sv
// Shared ARM execute-stage definitions: condition codes, NZCV bit positions
// and the EX/MEM control bundle.
package arm_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_write;
    logic undef;
  } exmem_ctrl_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: (cond, nzcv) -> pass.
module cond_check
  import arm_pkg::*;
#(
  parameter bit NV_EXEC = 1'b0
) (
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = nzcv_i[FLAG_N];
  assign z = nzcv_i[FLAG_Z];
  assign c = nzcv_i[FLAG_C];
  assign v = nzcv_i[FLAG_V];

  always_comb begin
    pass_o = 1'b0;
    case (cond_e'(cond_i))
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = z | (n != v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = NV_EXEC;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flags_stage.sv
// Execute-stage condition unit: NZCV register, condition gating of writes,
// EX/MEM control register and saturating executed/skipped counters.
module cond_flags_stage
  import arm_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter bit          NV_EXEC = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [3:0]       cond_i,
  input  logic [3:0]       alu_flags_i,
  input  logic [1:0]       flag_w_i,
  input  logic             pcs_i,
  input  logic             reg_w_i,
  input  logic             mem_w_i,
  input  logic             no_write_i,
  output logic             cond_ex_o,
  output logic             pc_src_o,
  output logic [3:0]       nzcv_o,
  output logic             m_valid_o,
  output logic             m_reg_write_o,
  output logic             m_mem_write_o,
  output logic             undef_o,
  output logic [CNT_W-1:0] exec_cnt_o,
  output logic [CNT_W-1:0] skip_cnt_o
);

  logic [3:0]       nzcv_q, nzcv_d;
  exmem_ctrl_t      ctrl_q, ctrl_d;
  logic [CNT_W-1:0] exec_q, exec_d;
  logic [CNT_W-1:0] skip_q, skip_d;
  logic             pass;
  logic             live;

  cond_check #(.NV_EXEC(NV_EXEC)) u_cond_check (
    .cond_i (cond_i),
    .nzcv_i (nzcv_q),
    .pass_o (pass)
  );

  assign live      = valid_i & ~flush_i;
  assign cond_ex_o = live & pass;
  assign pc_src_o  = pcs_i & cond_ex_o;

  always_comb begin
    nzcv_d = nzcv_q;
    ctrl_d = ctrl_q;
    exec_d = exec_q;
    skip_d = skip_q;
    if (!stall_i) begin
      if (cond_ex_o && flag_w_i[1]) begin
        nzcv_d[FLAG_N] = alu_flags_i[FLAG_N];
        nzcv_d[FLAG_Z] = alu_flags_i[FLAG_Z];
      end
      if (cond_ex_o && flag_w_i[0]) begin
        nzcv_d[FLAG_C] = alu_flags_i[FLAG_C];
        nzcv_d[FLAG_V] = alu_flags_i[FLAG_V];
      end
      ctrl_d.valid     = live;
      ctrl_d.reg_write = reg_w_i & ~no_write_i & cond_ex_o;
      ctrl_d.mem_write = mem_w_i & cond_ex_o;
      ctrl_d.undef     = live & (cond_i == COND_NV) & ~NV_EXEC;
      // Counters stick at all-ones rather than wrapping.
      if (live) begin
        if (pass) begin
          if (exec_q != '1) exec_d = exec_q + CNT_W'(1);
        end else begin
          if (skip_q != '1) skip_d = skip_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nzcv_q <= '0;
      ctrl_q <= '0;
      exec_q <= '0;
      skip_q <= '0;
    end else begin
      nzcv_q <= nzcv_d;
      ctrl_q <= ctrl_d;
      exec_q <= exec_d;
      skip_q <= skip_d;
    end
  end

  assign nzcv_o        = nzcv_q;
  assign m_valid_o     = ctrl_q.valid;
  assign m_reg_write_o = ctrl_q.reg_write;
  assign m_mem_write_o = ctrl_q.mem_write;
  assign undef_o       = ctrl_q.undef;
  assign exec_cnt_o    = exec_q;
  assign skip_cnt_o    = skip_q;

endmodule

// File: tb/tb_cond_flags_stage.sv
// Self-checking bench for cond_flags_stage: directed vector table, hand
// sequences for stall/saturation/reset, then randomized model comparison.
module tb_cond_flags_stage;

  localparam int unsigned CW      = 8;
  localparam bit          NV      = 1'b0;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          valid_i, stall_i, flush_i;
  logic [3:0]    cond_i, alu_flags_i;
  logic [1:0]    flag_w_i;
  logic          pcs_i, reg_w_i, mem_w_i, no_write_i;
  logic          cond_ex_o, pc_src_o;
  logic [3:0]    nzcv_o;
  logic          m_valid_o, m_reg_write_o, m_mem_write_o, undef_o;
  logic [CW-1:0] exec_cnt_o, skip_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cond_flags_stage #(.CNT_W(CW), .NV_EXEC(NV)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid_i      (valid_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .cond_i       (cond_i),
    .alu_flags_i  (alu_flags_i),
    .flag_w_i     (flag_w_i),
    .pcs_i        (pcs_i),
    .reg_w_i      (reg_w_i),
    .mem_w_i      (mem_w_i),
    .no_write_i   (no_write_i),
    .cond_ex_o    (cond_ex_o),
    .pc_src_o     (pc_src_o),
    .nzcv_o       (nzcv_o),
    .m_valid_o    (m_valid_o),
    .m_reg_write_o(m_reg_write_o),
    .m_mem_write_o(m_mem_write_o),
    .undef_o      (undef_o),
    .exec_cnt_o   (exec_cnt_o),
    .skip_cnt_o   (skip_cnt_o)
  );

  typedef struct {
    logic v, st, fl;
    logic [3:0] cond, alu;
    logic [1:0] fw;
    logic pcs, rw, mw, nw;
  } in_t;

  typedef struct {
    in_t i;
    logic ex, pc;
    logic [3:0] nzcv;
    logic mv, mr, mm, ud;
    int ec, sc;
  } vec_t;

  function automatic in_t mk_in(logic v, logic st, logic fl, logic [3:0] cond,
                                logic [3:0] alu, logic [1:0] fw, logic pcs,
                                logic rw, logic mw, logic nw);
    in_t r;
    r.v = v; r.st = st; r.fl = fl; r.cond = cond; r.alu = alu; r.fw = fw;
    r.pcs = pcs; r.rw = rw; r.mw = mw; r.nw = nw;
    return r;
  endfunction

  function automatic vec_t mk_vec(in_t i, logic ex, logic pc, logic [3:0] nzcv,
                                  logic mv, logic mr, logic mm, logic ud,
                                  int ec, int sc);
    vec_t r;
    r.i = i; r.ex = ex; r.pc = pc; r.nzcv = nzcv; r.mv = mv; r.mr = mr;
    r.mm = mm; r.ud = ud; r.ec = ec; r.sc = sc;
    return r;
  endfunction

  // Reference rule: even codes test a base predicate, odd codes its inverse.
  function automatic logic cond_pass(logic [3:0] c, logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hF) return NV;
    case (c >> 1)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic put(input in_t i);
    valid_i = i.v; stall_i = i.st; flush_i = i.fl; cond_i = i.cond;
    alu_flags_i = i.alu; flag_w_i = i.fw; pcs_i = i.pcs; reg_w_i = i.rw;
    mem_w_i = i.mw; no_write_i = i.nw;
  endtask

  task automatic check_regs(input string tag, input logic [3:0] nz, input logic mv,
                            input logic mr, input logic mm, input logic ud,
                            input int ec, input int sc);
    check({tag, ".nzcv"}, 32'(nzcv_o), 32'(nz));
    check({tag, ".m_valid"}, 32'(m_valid_o), 32'(mv));
    check({tag, ".m_reg_write"}, 32'(m_reg_write_o), 32'(mr));
    check({tag, ".m_mem_write"}, 32'(m_mem_write_o), 32'(mm));
    check({tag, ".undef"}, 32'(undef_o), 32'(ud));
    check({tag, ".exec_cnt"}, 32'(exec_cnt_o), 32'(ec));
    check({tag, ".skip_cnt"}, 32'(skip_cnt_o), 32'(sc));
  endtask

  vec_t vecs[15];
  in_t  idle, cur;

  logic [3:0] md_nzcv;
  logic md_mv, md_mr, md_mm, md_ud, md_live, md_ex;
  int md_ec, md_sc;

  initial begin
    idle = mk_in(0, 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
    //                 v  st fl cond   alu    fw    pcs rw mw nw     ex pc nzcv   mv mr mm ud ec sc
    vecs[0]  = mk_vec(mk_in(1, 0, 0, 4'hE, 4'h4, 2'b11, 0, 0, 0, 0), 1, 0, 4'h4, 1, 0, 0, 0, 1, 0);
    vecs[1]  = mk_vec(mk_in(1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0), 1, 0, 4'h4, 1, 1, 0, 0, 2, 0);
    vecs[2]  = mk_vec(mk_in(1, 0, 0, 4'h1, 4'h0, 2'b00, 0, 1, 0, 0), 0, 0, 4'h4, 1, 0, 0, 0, 2, 1);
    vecs[3]  = mk_vec(mk_in(1, 0, 0, 4'hE, 4'h0, 2'b11, 0, 0, 0, 0), 1, 0, 4'h0, 1, 0, 0, 0, 3, 1);
    vecs[4]  = mk_vec(mk_in(1, 0, 0, 4'hE, 4'hF, 2'b01, 0, 0, 0, 0), 1, 0, 4'h3, 1, 0, 0, 0, 4, 1);
    vecs[5]  = mk_vec(mk_in(1, 0, 0, 4'hE, 4'h9, 2'b11, 0, 0, 0, 0), 1, 0, 4'h9, 1, 0, 0, 0, 5, 1);
    vecs[6]  = mk_vec(mk_in(1, 0, 0, 4'hA, 4'h0, 2'b00, 0, 1, 0, 0), 1, 0, 4'h9, 1, 1, 0, 0, 6, 1);
    vecs[7]  = mk_vec(mk_in(1, 0, 0, 4'hB, 4'h0, 2'b00, 0, 1, 0, 0), 0, 0, 4'h9, 1, 0, 0, 0, 6, 2);
    vecs[8]  = mk_vec(mk_in(1, 0, 0, 4'hC, 4'h0, 2'b00, 0, 1, 0, 1), 1, 0, 4'h9, 1, 0, 0, 0, 7, 2);
    vecs[9]  = mk_vec(mk_in(1, 0, 0, 4'hE, 4'hC, 2'b11, 0, 0, 0, 0), 1, 0, 4'hC, 1, 0, 0, 0, 8, 2);
    vecs[10] = mk_vec(mk_in(1, 0, 0, 4'hD, 4'h0, 2'b00, 0, 0, 1, 0), 1, 0, 4'hC, 1, 0, 1, 0, 9, 2);
    vecs[11] = mk_vec(mk_in(1, 0, 0, 4'hC, 4'h0, 2'b00, 0, 0, 1, 0), 0, 0, 4'hC, 1, 0, 0, 0, 9, 3);
    vecs[12] = mk_vec(mk_in(1, 0, 1, 4'hE, 4'h0, 2'b11, 1, 1, 0, 0), 0, 0, 4'hC, 0, 0, 0, 0, 9, 3);
    vecs[13] = mk_vec(mk_in(1, 0, 0, 4'hF, 4'h0, 2'b11, 0, 1, 1, 0), 0, 0, 4'hC, 1, 0, 0, 1, 9, 4);
    vecs[14] = mk_vec(mk_in(0, 0, 0, 4'hE, 4'h0, 2'b11, 0, 1, 1, 0), 0, 0, 4'hC, 0, 0, 0, 0, 9, 4);

    reset_n = 1'b0;
    put(idle);
    #12;
    check_regs("reset", 4'h0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      put(vecs[k].i);
      #1;
      check($sformatf("vec%0d.cond_ex", k), 32'(cond_ex_o), 32'(vecs[k].ex));
      check($sformatf("vec%0d.pc_src", k), 32'(pc_src_o), 32'(vecs[k].pc));
      @(posedge clk);
      #1;
      check_regs($sformatf("vec%0d", k), vecs[k].nzcv, vecs[k].mv, vecs[k].mr,
                 vecs[k].mm, vecs[k].ud, vecs[k].ec, vecs[k].sc);
    end

    // NV instruction, then stall three cycles: undef_o and everything else hold.
    @(negedge clk);
    put(mk_in(1, 0, 0, 4'hF, 4'h0, 2'b00, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_regs("nv", 4'hC, 1, 0, 0, 1, 9, 5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      put(mk_in(1, 1, 0, 4'hE, 4'h0, 2'b11, 1, 1, 1, 0));
      #1;
      check("stall.cond_ex", 32'(cond_ex_o), 32'd1);
      check("stall.pc_src", 32'(pc_src_o), 32'd1);
      @(posedge clk);
      #1;
      check_regs($sformatf("stall%0d", k), 4'hC, 1, 0, 0, 1, 9, 5);
    end
    @(negedge clk);
    put(mk_in(1, 1, 1, 4'hE, 4'h0, 2'b11, 1, 1, 1, 0));
    #1;
    check("stallflush.cond_ex", 32'(cond_ex_o), 32'd0);
    check("stallflush.pc_src", 32'(pc_src_o), 32'd0);
    @(posedge clk);
    #1;
    check_regs("stallflush", 4'hC, 1, 0, 0, 1, 9, 5);
    @(negedge clk);
    put(idle);
    @(posedge clk);
    #1;
    check_regs("unstall", 4'hC, 0, 0, 0, 0, 9, 5);

    // Saturation: Z=1 so AL passes and NE fails; drive both past all-ones.
    for (int k = 0; k < 260; k++) begin
      @(negedge clk);
      put(mk_in(1, 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0));
      @(negedge clk);
      put(mk_in(1, 0, 0, 4'h1, 4'h0, 2'b00, 0, 0, 0, 0));
    end
    @(posedge clk);
    #1;
    check("sat.exec_cnt", 32'(exec_cnt_o), 32'(CNT_MAX));
    check("sat.skip_cnt", 32'(skip_cnt_o), 32'(CNT_MAX));

    // Asynchronous reset in the middle of a stall clears everything at once.
    @(negedge clk);
    put(mk_in(1, 1, 0, 4'hE, 4'h0, 2'b11, 0, 1, 0, 0));
    #2;
    reset_n = 1'b0;
    #1;
    check_regs("rst_in_stall", 4'h0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    put(idle);
    reset_n = 1'b1;

    md_nzcv = '0; md_mv = 0; md_mr = 0; md_mm = 0; md_ud = 0; md_ec = 0; md_sc = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        #1;
        md_nzcv = '0; md_mv = 0; md_mr = 0; md_mm = 0; md_ud = 0; md_ec = 0; md_sc = 0;
        check_regs("rnd_reset", md_nzcv, md_mv, md_mr, md_mm, md_ud, md_ec, md_sc);
        reset_n = 1'b1;
      end
      cur = mk_in($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 5) == 0, 4'($urandom), 4'($urandom),
                  2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) == 0);
      put(cur);
      #1;
      md_live = cur.v && !cur.fl;
      md_ex   = md_live && cond_pass(cur.cond, md_nzcv);
      check("rnd.cond_ex", 32'(cond_ex_o), 32'(md_ex));
      check("rnd.pc_src", 32'(pc_src_o), 32'(cur.pcs && md_ex));
      if (!cur.st) begin
        if (md_ex && cur.fw[1]) md_nzcv[3:2] = cur.alu[3:2];
        if (md_ex && cur.fw[0]) md_nzcv[1:0] = cur.alu[1:0];
        md_mv = md_live;
        md_mr = cur.rw && !cur.nw && md_ex;
        md_mm = cur.mw && md_ex;
        md_ud = md_live && cur.cond == 4'hF && !NV;
        if (md_live && md_ex) md_ec = (md_ec < CNT_MAX) ? md_ec + 1 : CNT_MAX;
        if (md_live && !md_ex) md_sc = (md_sc < CNT_MAX) ? md_sc + 1 : CNT_MAX;
      end
      @(posedge clk);
      #1;
      check_regs("rnd", md_nzcv, md_mv, md_mr, md_mm, md_ud, md_ec, md_sc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cond_flags_stage.md
Name: cond_flags_stage

Overview:
- Execute-stage condition unit directly downstream of the ALU.
- Holds the architectural NZCV register and evaluates each instruction's 4-bit condition field against it.
- Gates flag, register, memory and PC writes, and registers the gated controls into the EX/MEM pipeline register.
- Keeps saturating executed/skipped performance counters.

Parameters:
- CNT_W, 16, width of each performance counter.
- NV_EXEC, 0, 1 = cond 1111 executes like AL; 0 = cond 1111 never executes and raises undef_o.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid_i  in  1  an instruction is present in EX this cycle.
- stall_i  in  1  hold EX/MEM outputs, flags and counters.
- flush_i  in  1  kill the instruction in EX.
- cond_i  in  4  instruction condition field [31:28].
- alu_flags_i  in  4  ALU result flags {N,Z,C,V} (bit3..bit0).
- flag_w_i  in  2  bit1 = write N,Z; bit0 = write C,V.
- pcs_i  in  1  instruction writes PC.
- reg_w_i  in  1  instruction writes register file.
- mem_w_i  in  1  instruction writes memory.
- no_write_i  in  1  compare/test: suppress the register write.
- cond_ex_o  out  1  combinational: condition passed, valid_i=1 and flush_i=0.
- pc_src_o  out  1  combinational: pcs_i & cond_ex_o.
- nzcv_o  out  4  current flag register.
- m_valid_o  out  1  registered EX/MEM valid.
- m_reg_write_o  out  1  registered gated register write.
- m_mem_write_o  out  1  registered gated memory write.
- undef_o  out  1  registered one-cycle pulse for cond 1111 when NV_EXEC=0.
- exec_cnt_o  out  CNT_W  count of instructions that passed their condition.
- skip_cnt_o  out  CNT_W  count of instructions that failed their condition.

Behaviour:
- Reset (reset_n low, asynchronous): nzcv_o=0000; m_valid_o, m_reg_write_o, m_mem_write_o and undef_o = 0; both counters = 0. Deassertion takes effect at the next rising edge.
- Condition decode uses the registered nzcv_o, never alu_flags_i:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1.
  - 1111: true if NV_EXEC=1, else false.
- Flag write at a rising edge when cond_ex_o=1 and stall_i=0:
  - flag_w_i[1] set: N,Z <= alu_flags_i[3:2].
  - flag_w_i[0] set: C,V <= alu_flags_i[1:0].
  - Each half is written independently; nzcv_o is visible to the next instruction one cycle later. No bypass; back-to-back flag-set then conditional uses the new flags because EX holds one instruction per cycle.
- EX/MEM register, updated when stall_i=0:
  - m_valid_o <= valid_i & ~flush_i.
  - m_reg_write_o <= reg_w_i & ~no_write_i & cond_ex_o.
  - m_mem_write_o <= mem_w_i & cond_ex_o.
  - undef_o <= valid_i & ~flush_i & (cond_i==1111) & (NV_EXEC==0).
- stall_i=1: all registered state holds, including undef_o (it does not re-pulse), and counters do not advance. cond_ex_o and pc_src_o remain combinational.
- stall_i and flush_i both high: flush wins on the combinational outputs (cond_ex_o=0); registered state holds.
- Counters, updated when stall_i=0 and valid_i & ~flush_i: exec_cnt_o+1 if the condition passed, else skip_cnt_o+1. Both saturate at all-ones and never wrap.
- valid_i=0: no flag write, no counter change, gated writes = 0.
- Reset mid-stall or mid-flush: reset dominates and all state clears immediately.

Decomposition:
- Shared package arm_pkg holds:
  - condition-code constants COND_EQ..COND_NV;
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - a packed struct for the EX/MEM control bundle.
- One sub-module is natural: cond_check, purely combinational (cond, nzcv) -> pass. It is reused by any later branch-predict stage.

Test Plan:
- Reset, then SUBS-style op: flag_w_i=11, alu_flags_i=0100, cond_i=1110, valid_i=1 -> next cycle nzcv_o=0100, exec_cnt_o=1.
- With nzcv=0100: cond EQ, reg_w_i=1 -> m_reg_write_o=1; cond NE -> m_reg_write_o=0, cond_ex_o=0, skip_cnt_o increments.
- Partial write: nzcv=0000, flag_w_i=01, alu_flags_i=1111 -> nzcv_o=0011.
- Signed conditions: nzcv=1001 (N=V) -> GE=1, LT=0, GT=1; nzcv=1100 -> LE=1, GT=0.
- Branch with pcs_i=1, cond AL, flush_i=1 -> pc_src_o=0, m_valid_o=0, no flag write. With stall_i=1 -> outputs and counters hold for 3 cycles.
- Saturation and NV: preload counters to 0xFFFF with CNT_W=16, issue passing instruction -> stays 0xFFFF. cond 1111 with NV_EXEC=0 -> undef_o pulses one cycle, no writes.
